// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory for the data side of the Harvard core.
// Only one request/response transaction is in flight at a time.
// Features:
//   - configurable width and depth
//   - byte-lane write strobes
//   - programmable wait states between accept and response
//   - out-of-range error reporting
//
// Ports:
//   clk, rst_n   clock (rising edge) and synchronous active-low reset
//   req_valid    request present
//   req_ready    request can be accepted (high only in IDLE)
//   req_we       1 = store, 0 = load
//   req_addr     word address
//   req_wdata    store data
//   req_wstrb    byte-lane enables for stores
//   resp_valid   response present
//   resp_ready   consumer takes the response
//   resp_rdata   load data (0 for stores and errors)
//   resp_err     address >= DEPTH
module dmem_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int unsigned     STRB_W    = DATA_W / 8;
    localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Commit happens on the edge that enters RESP. With no wait states that
    // edge is the accept edge itself, so the live request inputs are used
    // instead of the latched copy.
    logic                c_en, c_we, c_in_range;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic [STRB_W-1:0]   c_wstrb;
    logic [IDX_W-1:0]    c_idx;

    always_comb begin
        c_en    = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wstrb = wstrb_q;
        if (state_q == ST_IDLE && req_valid && WAIT_CYCLES == 0) begin
            c_en    = 1'b1;
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else if (state_q == ST_WAIT && cnt_q == '0) begin
            c_en = 1'b1;
        end
        // A reset edge discards the transaction, including any pending write.
        c_en       = c_en & rst_n;
        c_in_range = ({1'b0, c_addr} < DEPTH_L);
        c_idx      = c_addr[IDX_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (c_en && c_we && c_in_range) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (c_wstrb[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (c_en) begin
            resp_rdata_d = (!c_we && c_in_range) ? mem[c_idx] : '0;
            resp_err_d   = !c_in_range;
        end
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule
